lab2_entry_pad: RTL

Input conditioning stage directly upstream of the two-digit combination lock.
- Synchronizes a raw push-button and a 4-bit raw switch bank to Clock, and debounces the button.
- Emits exactly one single-cycle Enter strobe per physical press.
- Presents the Digit value captured with that strobe, held stable until the next press.
- The lock consumes Enter and Digit directly, with no further conditioning.

---
 rtl/lab2_entry_pad.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lab2_entry_pad.sv
// lab2_entry_pad: synchronizes and debounces a raw push-button and 4-bit switch
// bank, and emits one registered Enter strobe per accepted press. Digit is captured
// from the switches on the Enter edge and held until the next accepted press.
//
// Ports:
//   Clock    - system clock, rising edge
//   Reset    - synchronous, active-high; overrides everything
//   Button   - raw asynchronous bouncing button, 1 = pressed
//   Switches - raw asynchronous digit switches
//   Enter    - single-cycle press strobe (registered)
//   Digit    - switch value captured with the most recent Enter (registered)
//   Busy     - high whenever State != IDLE
//   State    - FSM state code, for debug / observation
//
// Optional feature macro: ENTRY_HOLDOFF_EN. When it is defined, an accepted release
// is followed by HOLDOFF_CYCLES of dead time (HOLDOFF) before IDLE. When it is not
// defined, release goes straight to IDLE, and HOLDOFF behaves like an illegal code.
//
// Enter appears DEBOUNCE_CYCLES+2 edges after Button goes stably high: two edges of
// synchronizer, then one edge into PRESS_WAIT, then DEBOUNCE_CYCLES-1 edges counting.

module lab2_entry_pad #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 5,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button,
  input  logic [3:0] Switches,
  output logic       Enter,
  output logic [3:0] Digit,
  output logic       Busy,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_WAIT = 3'd3,
    HOLDOFF      = 3'd4
  } state_t;

  // Counter ceiling: the larger of the two terminal counts. The FSM never
  // counts past its terminal value, so this ceiling only guards against wrap.
  localparam int CNT_SAT = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 btn_m, btn_s;
  logic [3:0]           sw_m, sw_s;

  assign cnt_inc = (cnt >= CNT_WIDTH'(CNT_SAT)) ? cnt : cnt + CNT_WIDTH'(1);

  assign State = state;
  assign Busy  = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= 4'h0;
      sw_s  <= 4'h0;
      state <= IDLE;
      cnt   <= '0;
      Enter <= 1'b0;
      Digit <= 4'h0;
    end else begin
      btn_m <= Button;
      btn_s <= btn_m;
      sw_m  <= Switches;
      sw_s  <= sw_m;
      // Enter is a strobe: it is only raised on the edge entering PRESSED.
      Enter <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end else begin
            cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            Enter <= 1'b1;
            Digit <= sw_s;
          end else begin
            cnt <= cnt_inc;
          end
        end

        PRESSED: begin
          // Held button never repeats; only a falling btn_s moves on.
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end else begin
            cnt <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (btn_s) begin
            // Release bounce: back to PRESSED without a new strobe.
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
`ifdef ENTRY_HOLDOFF_EN
            state <= HOLDOFF;
`else
            state <= IDLE;
`endif
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

`ifdef ENTRY_HOLDOFF_EN
        HOLDOFF: begin
          // Dead time after release; btn_s is deliberately ignored here.
          if (cnt == CNT_WIDTH'(HOLDOFF_CYCLES - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
`endif

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
